// File: rtl/cnn_tile_fetch_seq.sv
// cnn_tile_fetch_seq: conv-layer tile sequencer and halo-aware inbuffer
// read-address generator. Optional CNN_TILE_FETCH_STAT_EN adds stat counters.
module cnn_tile_fetch_seq #(
  parameter int Ifm_width = 10,
  parameter int ADDR_W    = 20,
  parameter int TILE_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 layer_start,
  input  logic [ADDR_W-1:0]    fm_base,
  input  logic [Ifm_width-1:0] featuremap_W,
  input  logic [Ifm_width-1:0] featuremap_H,
  input  logic [Ifm_width-1:0] ifm_L,
  input  logic [Ifm_width-1:0] ifm_H,
  input  logic [Ifm_width-1:0] channels,
  input  logic [2:0]           kernel_size,
  input  logic                 tile_done_i,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic                 rd_pad,
  output logic                 rd_last,
  output logic [TILE_W-1:0]    tile_num,
  output logic                 out_last,
`ifdef CNN_TILE_FETCH_STAT_EN
  output logic [23:0]          stat_words,
  output logic [23:0]          stat_pads,
`endif
  output logic                 busy
);

  localparam int CW   = Ifm_width + 2;
  localparam int NT_W = 2 * Ifm_width;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  function automatic logic [2:0] cg_shift(
    input logic [Ifm_width-1:0] ch
  );
    logic [2:0] s;
    s = 3'd0;
    for (int i = 5; i < 10; i++)
      if (ch[i]) s = 3'(i - 4);
    return s;
  endfunction

  logic [1:0]           state_q, state_d;
  logic [Ifm_width-1:0] fm_w_q, fm_w_d;
  logic [Ifm_width-1:0] fm_h_q, fm_h_d;
  logic [Ifm_width-1:0] til_l_q, til_l_d;
  logic [Ifm_width-1:0] til_h_q, til_h_d;
  logic [4:0]           cg_m1_q, cg_m1_d;
  logic [2:0]           sh_q, sh_d;
  logic [1:0]           halo_q, halo_d;
  logic [ADDR_W-1:0]    rs_q, rs_d;
  logic [Ifm_width-1:0] rem_w_q, rem_w_d;
  logic [Ifm_width-1:0] rem_h_q, rem_h_d;
  logic [Ifm_width-1:0] n_w_q, n_w_d;
  logic [NT_W-1:0]      n_tiles_q, n_tiles_d;
  logic [ADDR_W-1:0]    mcand_q, mcand_d;
  logic [Ifm_width-1:0] mplier_q, mplier_d;
  logic [ADDR_W-1:0]    row_step_q, row_step_d;
  logic [TILE_W-1:0]    tile_num_q, tile_num_d;
  logic [Ifm_width-1:0] tx_q, tx_d;
  logic [Ifm_width-1:0] x0_q, x0_d;
  logic [Ifm_width-1:0] y0_q, y0_d;
  logic [ADDR_W-1:0]    tile_base_q, tile_base_d;
  logic [ADDR_W-1:0]    trow_base_q, trow_base_d;
  logic [CW-1:0]        x_q, x_d;
  logic [CW-1:0]        y_q, y_d;
  logic [4:0]           c_q, c_d;
  logic [ADDR_W-1:0]    raw_q, raw_d;
  logic [ADDR_W-1:0]    rowst_q, rowst_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 out_last_q, out_last_d;
  logic                 done_pend_q, done_pend_d;

  logic [Ifm_width-1:0] diff_w, diff_h, tw, th;
  logic [CW-1:0]        x_st, x_end, y_st, y_end;
  logic [ADDR_W-1:0]    rs_in, col_step, hv, halo_off;
  logic                 pad_w, last_w;

  // Current tile window bounds and derived address steps
  always_comb begin
    diff_w   = fm_w_q - x0_q;
    diff_h   = fm_h_q - y0_q;
    tw       = (diff_w < til_l_q) ? diff_w : til_l_q;
    th       = (diff_h < til_h_q) ? diff_h : til_h_q;
    x_st     = {2'b00, x0_q} - CW'(halo_q);
    y_st     = {2'b00, y0_q} - CW'(halo_q);
    x_end    = {2'b00, x0_q} + {2'b00, tw}
             - CW'(1) + CW'(halo_q);
    y_end    = {2'b00, y0_q} + {2'b00, th}
             - CW'(1) + CW'(halo_q);
    rs_in    = ADDR_W'(featuremap_W) << cg_shift(channels);
    col_step = ADDR_W'(til_l_q) << sh_q;
    hv       = rs_q + ADDR_W'(cg_m1_q) + ADDR_W'(1);
    halo_off = (halo_q[0] ? hv : '0)
             + (halo_q[1] ? (hv << 1) : '0);
    pad_w    = (x_q >= {2'b00, fm_w_q})
             | (y_q >= {2'b00, fm_h_q});
    last_w   = (x_q == x_end) & (y_q == y_end)
             & (c_q == cg_m1_q);
  end

  // Sequencer: geometry setup, word walk, tile handoff
  always_comb begin
    state_d     = state_q;
    fm_w_d      = fm_w_q;
    fm_h_d      = fm_h_q;
    til_l_d     = til_l_q;
    til_h_d     = til_h_q;
    cg_m1_d     = cg_m1_q;
    sh_d        = sh_q;
    halo_d      = halo_q;
    rs_d        = rs_q;
    rem_w_d     = rem_w_q;
    rem_h_d     = rem_h_q;
    n_w_d       = n_w_q;
    n_tiles_d   = n_tiles_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    row_step_d  = row_step_q;
    tile_num_d  = tile_num_q;
    tx_d        = tx_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    tile_base_d = tile_base_q;
    trow_base_d = trow_base_q;
    x_d         = x_q;
    y_d         = y_q;
    c_d         = c_q;
    raw_d       = raw_q;
    rowst_d     = rowst_q;
    rd_valid_d  = rd_valid_q;
    out_last_d  = out_last_q;
    done_pend_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (layer_start) begin
          state_d     = S_SETUP;
          fm_w_d      = featuremap_W;
          fm_h_d      = featuremap_H;
          til_l_d     = ifm_L;
          til_h_d     = ifm_H;
          cg_m1_d     = 5'((channels >> 4) - 1'b1);
          sh_d        = cg_shift(channels);
          halo_d      = 2'(kernel_size >> 1);
          rs_d        = rs_in;
          rem_w_d     = featuremap_W;
          rem_h_d     = featuremap_H;
          n_w_d       = '0;
          n_tiles_d   = '0;
          mcand_d     = rs_in;
          mplier_d    = ifm_H;
          row_step_d  = '0;
          tile_num_d  = '0;
          tx_d        = '0;
          x0_d        = '0;
          y0_d        = '0;
          tile_base_d = fm_base;
          trow_base_d = fm_base;
          out_last_d  = 1'b0;
          rd_valid_d  = 1'b0;
        end
      end
      S_SETUP: begin
        if (rem_w_q != '0) begin
          n_w_d   = n_w_q + 1'b1;
          rem_w_d = (rem_w_q > til_l_q)
                  ? rem_w_q - til_l_q : '0;
        end else if (rem_h_q != '0) begin
          n_tiles_d = n_tiles_q + NT_W'(n_w_q);
          rem_h_d   = (rem_h_q > til_h_q)
                    ? rem_h_q - til_h_q : '0;
        end
        if (mplier_q != '0) begin
          if (mplier_q[0])
            row_step_d = row_step_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        if (rem_w_q == '0 && rem_h_q == '0
            && mplier_q == '0) begin
          state_d    = S_FETCH;
          out_last_d = (n_tiles_q == NT_W'(1));
        end
      end
      S_FETCH: begin
        done_pend_d = done_pend_q | tile_done_i;
        if (!rd_valid_q) begin
          rd_valid_d = 1'b1;
          x_d        = x_st;
          y_d        = y_st;
          c_d        = '0;
          raw_d      = tile_base_q - halo_off;
          rowst_d    = tile_base_q - halo_off;
        end else if (rd_ready) begin
          if (last_w) begin
            state_d    = S_WAIT;
            rd_valid_d = 1'b0;
          end else if (c_q != cg_m1_q) begin
            c_d   = c_q + 1'b1;
            raw_d = raw_q + 1'b1;
          end else begin
            c_d = '0;
            if (x_q != x_end) begin
              x_d   = x_q + 1'b1;
              raw_d = raw_q + 1'b1;
            end else begin
              x_d     = x_st;
              y_d     = y_q + 1'b1;
              raw_d   = rowst_q + rs_q;
              rowst_d = rowst_q + rs_q;
            end
          end
        end
      end
      S_WAIT: begin
        if (done_pend_q | tile_done_i) begin
          if (NT_W'(tile_num_q) < n_tiles_q - 1'b1) begin
            state_d    = S_FETCH;
            tile_num_d = tile_num_q + 1'b1;
            out_last_d = (NT_W'(tile_num_q) + NT_W'(2))
                       == n_tiles_q;
            if (tx_q == n_w_q - 1'b1) begin
              tx_d        = '0;
              x0_d        = '0;
              y0_d        = y0_q + til_h_q;
              trow_base_d = trow_base_q + row_step_q;
              tile_base_d = trow_base_q + row_step_q;
            end else begin
              tx_d        = tx_q + 1'b1;
              x0_d        = x0_q + til_l_q;
              tile_base_d = tile_base_q + col_step;
            end
          end else begin
            state_d    = S_IDLE;
            out_last_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fm_w_q      <= '0;
      fm_h_q      <= '0;
      til_l_q     <= '0;
      til_h_q     <= '0;
      cg_m1_q     <= '0;
      sh_q        <= '0;
      halo_q      <= '0;
      rs_q        <= '0;
      rem_w_q     <= '0;
      rem_h_q     <= '0;
      n_w_q       <= '0;
      n_tiles_q   <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      row_step_q  <= '0;
      tile_num_q  <= '0;
      tx_q        <= '0;
      x0_q        <= '0;
      y0_q        <= '0;
      tile_base_q <= '0;
      trow_base_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      c_q         <= '0;
      raw_q       <= '0;
      rowst_q     <= '0;
      rd_valid_q  <= 1'b0;
      out_last_q  <= 1'b0;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fm_w_q      <= fm_w_d;
      fm_h_q      <= fm_h_d;
      til_l_q     <= til_l_d;
      til_h_q     <= til_h_d;
      cg_m1_q     <= cg_m1_d;
      sh_q        <= sh_d;
      halo_q      <= halo_d;
      rs_q        <= rs_d;
      rem_w_q     <= rem_w_d;
      rem_h_q     <= rem_h_d;
      n_w_q       <= n_w_d;
      n_tiles_q   <= n_tiles_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      row_step_q  <= row_step_d;
      tile_num_q  <= tile_num_d;
      tx_q        <= tx_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      tile_base_q <= tile_base_d;
      trow_base_q <= trow_base_d;
      x_q         <= x_d;
      y_q         <= y_d;
      c_q         <= c_d;
      raw_q       <= raw_d;
      rowst_q     <= rowst_d;
      rd_valid_q  <= rd_valid_d;
      out_last_q  <= out_last_d;
      done_pend_q <= done_pend_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_pad   = rd_valid_q & pad_w;
  assign rd_last  = rd_valid_q & last_w;
  assign rd_addr  = (rd_valid_q & ~pad_w) ? raw_q : '0;
  assign tile_num = tile_num_q;
  assign out_last = out_last_q;
  assign busy     = (state_q != S_IDLE);

`ifdef CNN_TILE_FETCH_STAT_EN
  logic [23:0] stat_words_q, stat_words_d;
  logic [23:0] stat_pads_q, stat_pads_d;

  // Saturating counts of accepted words and pad words per layer
  always_comb begin
    stat_words_d = stat_words_q;
    stat_pads_d  = stat_pads_q;
    if (state_q == S_IDLE && layer_start) begin
      stat_words_d = '0;
      stat_pads_d  = '0;
    end else if (rd_valid_q && rd_ready) begin
      if (stat_words_q != '1)
        stat_words_d = stat_words_q + 1'b1;
      if (pad_w && stat_pads_q != '1)
        stat_pads_d = stat_pads_q + 1'b1;
    end
  end

  // Stat registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_words_q <= '0;
      stat_pads_q  <= '0;
    end else begin
      stat_words_q <= stat_words_d;
      stat_pads_q  <= stat_pads_d;
    end
  end

  assign stat_words = stat_words_q;
  assign stat_pads  = stat_pads_q;
`endif

endmodule
